// File: rtl/hog_cell_sequencer.sv
// -----------------------------------------------------------------------------
// hog_cell_sequencer
//
// Frame-level controller in front of hog_feature_gen. Cells come in from the
// histogram stage over a valid/ready handshake. They are paced so that at
// least MIN_GAP idle cycles separate two issued cells. Each cell is forwarded
// to the feature generator with its cell index and frame-window address. The
// frame-window address is 0 during the single CLEAR cycle, which clears the
// generator. The sequencer then counts the normalized blocks that come back,
// and uses that count to detect the end of the frame.
//
// Optional feature:
//   HOG_SEQ_WDOG_EN - when defined, a watchdog runs in FLUSH. If no block
//                     arrives for TIMEOUT cycles, it pulses err and abandons
//                     the frame. When undefined, err is tied 0 and FLUSH
//                     waits indefinitely.
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active low
//   start       begin a frame (honoured only in IDLE, not while done is high)
//   cell_bin    upstream cell histogram, 9 bins of BIN_I+BIN_F bits
//   cell_valid  upstream valid
//   cell_ready  sequencer can accept a cell (combinational)
//   fg_addr_fw  frame-window address to feature gen, 0 = clear
//   fg_address  cell index to feature gen
//   fg_bin      registered histogram to feature gen
//   fg_valid    histogram valid to feature gen
//   fg_o_valid  block-feature valid from feature gen
//   busy        high from CLEAR through FLUSH
//   blk_cnt     blocks received this frame (saturates at N_BLK)
//   done        one-cycle pulse, frame complete
//   err         one-cycle pulse, watchdog expired
// -----------------------------------------------------------------------------
module hog_cell_sequencer #(
    parameter int ADDR_W    = 10,
    parameter int BIN_I     = 16,
    parameter int BIN_F     = 16,
    parameter int BID_W     = 13,
    parameter int CELL_COLS = 40,
    parameter int CELL_ROWS = 20,
    parameter int MIN_GAP   = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [9*(BIN_I+BIN_F)-1:0]   cell_bin,
    input  logic                         cell_valid,
    output logic                         cell_ready,
    output logic [ADDR_W-1:0]            fg_addr_fw,
    output logic [ADDR_W-1:0]            fg_address,
    output logic [9*(BIN_I+BIN_F)-1:0]   fg_bin,
    output logic                         fg_valid,
    input  logic                         fg_o_valid,
    output logic                         busy,
    output logic [BID_W-1:0]             blk_cnt,
    output logic                         done,
    output logic                         err
);

    localparam int BIN_W  = 9 * (BIN_I + BIN_F);
    localparam int N_CELL = CELL_COLS * CELL_ROWS;
    localparam int N_BLK  = (CELL_COLS - 1) * (CELL_ROWS - 1);
    localparam int GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(N_CELL - 1);
    localparam logic [BID_W-1:0]  BLK_FULL  = BID_W'(N_BLK);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MIN_GAP);

    // The frame must fit the address space: fg_addr_fw reaches N_CELL.
    if (N_CELL >= (2 ** ADDR_W) || TIMEOUT < 1) begin : g_bad_cfg
        $error("hog_cell_sequencer: N_CELL must be < 2**ADDR_W and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   cell_idx, cell_idx_n;
    logic [GAP_W-1:0]    gap_cnt, gap_n;
    logic [ADDR_W-1:0]   fw_n, addr_n;
    logic [BIN_W-1:0]    bin_n;
    logic [BID_W-1:0]    blk_n;
    logic                valid_n, done_n, busy_n;
    logic                accept, blk_hit;

`ifdef HOG_SEQ_WDOG_EN
    localparam int             WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT - 1);

    // Counts cycles since the last block (or FLUSH entry); the value 1 marks
    // the first cycle after that event, so err lands TIMEOUT cycles later.
    logic [WD_W-1:0] wdog, wdog_n;
    logic            err_n;
`endif

    assign cell_ready = (state == RUN) && (gap_cnt == '0);
    assign accept     = cell_valid && cell_ready;
    // Blocks count only once the generator has been cleared, and stop at the
    // frame total so stray extra pulses cannot wrap the counter.
    assign blk_hit    = fg_o_valid && (state == RUN || state == FLUSH) && (blk_cnt != BLK_FULL);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_n    = state;
        cell_idx_n = cell_idx;
        gap_n      = gap_cnt;
        fw_n       = fg_addr_fw;
        addr_n     = fg_address;
        bin_n      = fg_bin;
        blk_n      = blk_cnt;
        valid_n    = 1'b0;
        done_n     = 1'b0;
`ifdef HOG_SEQ_WDOG_EN
        wdog_n     = wdog;
        err_n      = 1'b0;
`endif

        if (gap_cnt != '0) begin
            gap_n = gap_cnt - 1'b1;
        end
        if (blk_hit) begin
            blk_n = blk_cnt + 1'b1;
        end

        unique case (state)
            IDLE: begin
                fw_n = '0;
                // A start coinciding with the done pulse belongs to the old
                // frame's handshake and is dropped.
                if (start && !done) begin
                    state_n    = CLEAR;
                    cell_idx_n = '0;
                    blk_n      = '0;
                    gap_n      = '0;
                end
            end

            CLEAR: begin
                fw_n    = '0;
                state_n = RUN;
            end

            RUN: begin
                if (accept) begin
                    valid_n    = 1'b1;
                    bin_n      = cell_bin;
                    addr_n     = cell_idx;
                    fw_n       = cell_idx + 1'b1;
                    cell_idx_n = cell_idx + 1'b1;
                    gap_n      = GAP_LOAD;
                    if (cell_idx == LAST_CELL) begin
                        state_n = FLUSH;
`ifdef HOG_SEQ_WDOG_EN
                        wdog_n  = WD_W'(1);
`endif
                    end
                end
            end

            FLUSH: begin
                // blk_n already includes a pulse arriving this cycle.
                if (blk_n == BLK_FULL) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    fw_n    = '0;
                end
`ifdef HOG_SEQ_WDOG_EN
                else if (fg_o_valid) begin
                    wdog_n = WD_W'(1);
                end else if (wdog >= WD_LIM) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                    fw_n    = '0;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
`endif
            end

            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: fg_bin is a wide datapath register, but it is reset as well so every output reads 0 out of reset.
            state      <= IDLE;
            cell_idx   <= '0;
            gap_cnt    <= '0;
            fg_addr_fw <= '0;
            fg_address <= '0;
            fg_bin     <= '0;
            fg_valid   <= 1'b0;
            blk_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
            state      <= state_n;
            cell_idx   <= cell_idx_n;
            gap_cnt    <= gap_n;
            fg_addr_fw <= fw_n;
            fg_address <= addr_n;
            fg_bin     <= bin_n;
            fg_valid   <= valid_n;
            blk_cnt    <= blk_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

`ifdef HOG_SEQ_WDOG_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog <= '0;
            err  <= 1'b0;
        end else begin
            wdog <= wdog_n;
            err  <= err_n;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hog_cell_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hog_cell_sequencer
//
// Two sequencers on a 4x3 cell frame: unit 0 with MIN_GAP=0, unit 1 with
// MIN_GAP=2. Both share clk/rst. A frame-level reference model per unit
// tracks the following: frame in progress, edge of the start, cells issued,
// edge of the last issue, and blocks received. The model predicts the
// handshake and outputs every cycle. Outputs are sampled 1 time unit after
// the rising edge. Define HOG_SEQ_WDOG_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_hog_cell_sequencer;

    localparam int ADDR_W  = 10;
    localparam int BIN_I   = 16;
    localparam int BIN_F   = 16;
    localparam int BID_W   = 13;
    localparam int COLS    = 4;
    localparam int ROWS    = 3;
    localparam int TIMEOUT = 8;
    localparam int BW      = 9 * (BIN_I + BIN_F);
    localparam int N_CELL  = COLS * ROWS;
    localparam int N_BLK   = (COLS - 1) * (ROWS - 1);

    logic clk = 1'b0;
    logic rst;

    logic              start_s [2];
    logic              valid_s [2];
    logic              ov_s    [2];
    logic [BW-1:0]     bin_s   [2];

    logic              ready_o [2];
    logic              fgv_o   [2];
    logic              busy_o  [2];
    logic              done_o  [2];
    logic              err_o   [2];
    logic [ADDR_W-1:0] fw_o    [2];
    logic [ADDR_W-1:0] addr_o  [2];
    logic [BW-1:0]     fbin_o  [2];
    logic [BID_W-1:0]  blk_o   [2];

    always #5 clk = ~clk;

    hog_cell_sequencer #(
        .ADDR_W(ADDR_W), .BIN_I(BIN_I), .BIN_F(BIN_F), .BID_W(BID_W),
        .CELL_COLS(COLS), .CELL_ROWS(ROWS), .MIN_GAP(0), .TIMEOUT(TIMEOUT)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]),
        .cell_bin(bin_s[0]), .cell_valid(valid_s[0]), .cell_ready(ready_o[0]),
        .fg_addr_fw(fw_o[0]), .fg_address(addr_o[0]), .fg_bin(fbin_o[0]),
        .fg_valid(fgv_o[0]), .fg_o_valid(ov_s[0]), .busy(busy_o[0]),
        .blk_cnt(blk_o[0]), .done(done_o[0]), .err(err_o[0])
    );

    hog_cell_sequencer #(
        .ADDR_W(ADDR_W), .BIN_I(BIN_I), .BIN_F(BIN_F), .BID_W(BID_W),
        .CELL_COLS(COLS), .CELL_ROWS(ROWS), .MIN_GAP(2), .TIMEOUT(TIMEOUT)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]),
        .cell_bin(bin_s[1]), .cell_valid(valid_s[1]), .cell_ready(ready_o[1]),
        .fg_addr_fw(fw_o[1]), .fg_address(addr_o[1]), .fg_bin(fbin_o[1]),
        .fg_valid(fgv_o[1]), .fg_o_valid(ov_s[1]), .busy(busy_o[1]),
        .blk_cnt(blk_o[1]), .done(done_o[1]), .err(err_o[1])
    );

    // Reference model state, one entry per unit.
    bit            m_on    [2];
    int            m_start [2];
    int            m_iss   [2];
    int            m_last  [2];
    int            m_blk   [2];
    int            m_fw    [2];
    int            m_addr  [2];
    bit            m_valid [2];
    bit            m_done  [2];
    bit            m_err   [2];
    bit            m_wipe  [2];
    logic [BW-1:0] m_bin   [2];
`ifdef HOG_SEQ_WDOG_EN
    int            m_ref   [2];
`endif

    int obs_valid [2];
    int obs_done  [2];
    int obs_err   [2];
    int edge_n;
    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int gap_of(input int u);
        return (u == 0) ? 0 : 2;
    endfunction

    function automatic logic [BW-1:0] rand_bin();
        logic [BW-1:0] b;
        for (int i = 0; i < 9; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // A cell is takeable at edge e once the clear cycle is over, the frame
    // still needs cells, and MIN_GAP+1 edges have passed since the last issue.
    function automatic bit exp_ready(input int u, input int e);
        return m_on[u] && (e - m_start[u] >= 2) && (m_iss[u] < N_CELL) &&
               (m_iss[u] == 0 || e - m_last[u] >= gap_of(u) + 1);
    endfunction

    function automatic void model_update(input int u, input bit acc);
        bit done_prev;
        bit flushing;
        bit pulse;
        done_prev  = m_done[u];
        m_valid[u] = 1'b0;
        m_done[u]  = 1'b0;
        m_err[u]   = 1'b0;
        m_wipe[u]  = 1'b0;
        if (!rst) begin
            m_on[u]   = 1'b0;
            m_blk[u]  = 0;
            m_fw[u]   = 0;
            m_wipe[u] = 1'b1;
        end else if (!m_on[u]) begin
            if (start_s[u] && !done_prev) begin
                m_on[u]    = 1'b1;
                m_start[u] = edge_n;
                m_iss[u]   = 0;
                m_blk[u]   = 0;
                m_fw[u]    = 0;
            end
        end else begin
            flushing = (m_iss[u] == N_CELL);
            pulse    = ov_s[u] && (edge_n - m_start[u] >= 2);
            if (pulse && m_blk[u] < N_BLK) m_blk[u]++;
            if (acc) begin
                m_valid[u] = 1'b1;
                m_bin[u]   = bin_s[u];
                m_addr[u]  = m_iss[u];
                m_fw[u]    = m_iss[u] + 1;
                m_iss[u]++;
                m_last[u]  = edge_n;
`ifdef HOG_SEQ_WDOG_EN
                m_ref[u]   = edge_n;
`endif
            end
            if (flushing) begin
                if (m_blk[u] == N_BLK) begin
                    m_done[u] = 1'b1;
                    m_on[u]   = 1'b0;
                    m_fw[u]   = 0;
                end
`ifdef HOG_SEQ_WDOG_EN
                else if (pulse) begin
                    m_ref[u] = edge_n;
                end else if (edge_n - m_ref[u] >= TIMEOUT - 1) begin
                    m_err[u] = 1'b1;
                    m_on[u]  = 1'b0;
                    m_fw[u]  = 0;
                end
`endif
            end
        end
    endfunction

    task automatic check_outputs(input int u);
        string p;
        p = $sformatf("u%0d e%0d", u, edge_n);
        check({p, " busy"},     BW'(busy_o[u]), BW'(m_on[u]));
        check({p, " fg_valid"}, BW'(fgv_o[u]),  BW'(m_valid[u]));
        check({p, " done"},     BW'(done_o[u]), BW'(m_done[u]));
        check({p, " err"},      BW'(err_o[u]),  BW'(m_err[u]));
        check({p, " blk_cnt"},  BW'(blk_o[u]),  BW'(m_blk[u]));
        if (m_valid[u]) begin
            check({p, " fg_address"}, BW'(addr_o[u]), BW'(m_addr[u]));
            check({p, " fg_bin"},     fbin_o[u],       m_bin[u]);
        end
        if (!m_on[u] || edge_n == m_start[u] || m_valid[u] || m_iss[u] == N_CELL)
            check({p, " fg_addr_fw"}, BW'(fw_o[u]), BW'(m_fw[u]));
        if (m_wipe[u]) begin
            check({p, " rst fg_address"}, BW'(addr_o[u]), '0);
            check({p, " rst fg_bin"},     fbin_o[u],       '0);
        end
        obs_valid[u] += int'(fgv_o[u]);
        obs_done[u]  += int'(done_o[u]);
        obs_err[u]   += int'(err_o[u]);
    endtask

    // One clock: check cell_ready for the coming edge, clock, update model, check outputs.
    task automatic step();
        bit acc [2];
        for (int u = 0; u < 2; u++) begin
            acc[u] = exp_ready(u, edge_n + 1);
            check($sformatf("u%0d e%0d cell_ready", u, edge_n + 1), BW'(ready_o[u]), BW'(acc[u]));
            acc[u] = acc[u] && valid_s[u];
        end
        @(posedge clk);
        edge_n++;
        for (int u = 0; u < 2; u++) model_update(u, acc[u]);
        #1;
        for (int u = 0; u < 2; u++) check_outputs(u);
    endtask

    task automatic quiet();
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0;
            valid_s[u] = 1'b0;
            ov_s[u]    = 1'b0;
        end
    endtask

    initial begin
        int v0, d0, e0;
        n_checks = 0;
        n_pass   = 0;
        edge_n   = 0;
        rst      = 1'b0;
        for (int u = 0; u < 2; u++) begin
            bin_s[u] = '0;   m_on[u] = 1'b0;  m_start[u] = 0; m_iss[u] = 0;
            m_last[u] = 0;   m_blk[u] = 0;    m_fw[u] = 0;    m_addr[u] = 0;
            m_valid[u] = 0;  m_done[u] = 0;   m_err[u] = 0;   m_wipe[u] = 0;
            m_bin[u] = '0;   obs_valid[u] = 0; obs_done[u] = 0; obs_err[u] = 0;
`ifdef HOG_SEQ_WDOG_EN
            m_ref[u] = 0;
`endif
        end
        quiet();
        @(posedge clk);
        #1;
        repeat (3) step();
        rst = 1'b1;

        // Back-to-back cells on unit 0, with start poked during RUN.
        v0 = obs_valid[0];
        start_s[0] = 1'b1; step(); start_s[0] = 1'b0;
        valid_s[0] = 1'b1;
        for (int g = 0; g < 40 && m_iss[0] < N_CELL; g++) begin
            bin_s[0]   = rand_bin();
            start_s[0] = ($urandom_range(0, 3) == 0);
            step();
        end
        quiet();
        check("A fg_valid count", BW'(obs_valid[0] - v0), BW'(N_CELL));
        ov_s[0] = 1'b1;
        repeat (N_BLK) step();
        ov_s[0] = 1'b0;
        check("A done after last block", BW'(done_o[0]), BW'(1));
        check("A blk_cnt final", BW'(blk_o[0]), BW'(N_BLK));
        start_s[0] = 1'b1; step(); start_s[0] = 1'b0;
        check("A start with done ignored", BW'(busy_o[0]), BW'(0));
        repeat (3) step();
        start_s[0] = 1'b1; step(); start_s[0] = 1'b0;
        check("A clear cycle fw", BW'(fw_o[0]), BW'(0));
        check("A clear cycle busy", BW'(busy_o[0]), BW'(1));

        // Paced cells on unit 1 (MIN_GAP=2).
        v0 = obs_valid[1];
        d0 = obs_done[1];
        start_s[1] = 1'b1; step(); start_s[1] = 1'b0;
        valid_s[1] = 1'b1;
        for (int g = 0; g < 80 && m_iss[1] < N_CELL; g++) begin
            bin_s[1] = rand_bin();
            step();
        end
        valid_s[1] = 1'b0;
        check("B fg_valid count", BW'(obs_valid[1] - v0), BW'(N_CELL));
        for (int g = 0; g < 100 && m_on[1]; g++) begin
            ov_s[1] = (g % 2 == 0);
            step();
        end
        ov_s[1] = 1'b0;
        check("B done count", BW'(obs_done[1] - d0), BW'(1));

`ifdef HOG_SEQ_WDOG_EN
        // Unit 0 is in RUN: feed all cells, return only 4 blocks.
        d0 = obs_done[0];
        e0 = obs_err[0];
        valid_s[0] = 1'b1;
        for (int g = 0; g < 40 && m_iss[0] < N_CELL; g++) begin
            bin_s[0] = rand_bin();
            step();
        end
        valid_s[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ov_s[0] = 1'b1; step();
            ov_s[0] = 1'b0; step();
        end
        for (int g = 0; g < 30 && m_on[0]; g++) step();
        check("W err count", BW'(obs_err[0] - e0), BW'(1));
        check("W no done", BW'(obs_done[0] - d0), BW'(0));
        check("W blk_cnt partial", BW'(blk_o[0]), BW'(4));
`endif

        // Random traffic on both units.
        for (int g = 0; g < 800; g++) begin
            for (int u = 0; u < 2; u++) begin
                start_s[u] = ($urandom_range(0, 9) == 0);
                valid_s[u] = $urandom_range(0, 1);
                ov_s[u]    = ($urandom_range(0, 3) == 0);
                bin_s[u]   = rand_bin();
            end
            step();
        end
        quiet();

        // Reset in the middle of a frame on unit 0, then a clean restart.
        rst = 1'b0; step(); rst = 1'b1;
        start_s[0] = 1'b1; step(); start_s[0] = 1'b0;
        valid_s[0] = 1'b1;
        for (int g = 0; g < 40 && m_iss[0] < 5; g++) begin
            bin_s[0] = rand_bin();
            step();
        end
        rst = 1'b0; step(); rst = 1'b1;
        valid_s[0] = 1'b0;
        check("R busy after reset", BW'(busy_o[0]), BW'(0));
        check("R fg_address after reset", BW'(addr_o[0]), BW'(0));
        check("R fg_addr_fw after reset", BW'(fw_o[0]), BW'(0));
        step();
        v0 = obs_valid[0];
        d0 = obs_done[0];
        start_s[0] = 1'b1; step(); start_s[0] = 1'b0;
        valid_s[0] = 1'b1;
        for (int g = 0; g < 40 && m_iss[0] < N_CELL; g++) begin
            bin_s[0] = rand_bin();
            step();
        end
        valid_s[0] = 1'b0;
        check("R fg_valid count", BW'(obs_valid[0] - v0), BW'(N_CELL));
        ov_s[0] = 1'b1;
        for (int g = 0; g < 20 && m_on[0]; g++) step();
        ov_s[0] = 1'b0;
        step();
        check("R done count", BW'(obs_done[0] - d0), BW'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
